// File: rtl/i2s_tx_unit.sv
// I2S transmitter: single-entry sample holding buffer feeding a 48-bit frame
// serialiser (24 bits per channel, MSB first, one-bit WS delay) with a per-frame request.
module i2s_tx_unit #(
  parameter int MCLK_DIV = 4,
  parameter int REQ_LEN  = 8
) (
  input  logic        rsync_clk,
  input  logic        rst_n,
  input  logic        play_in,
  input  logic        tick_in,
  input  logic [23:0] audio0_in,
  input  logic [23:0] audio1_in,
  output logic        req_out,
  output logic        sck_out,
  output logic        ws_out,
  output logic        sdo_out,
  output logic        underrun_out
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam int DW = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int RW = $clog2(48 * MCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV / 2);

  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next, div_adv;
  logic [5:0]    bit_reg, bit_next, bit_adv;
  logic          div_wrap, frame_end, load_next;
  logic          sck_reg, sck_next, ws_reg, ws_next, sdo_reg, sdo_next;
  logic [5:0]    sdo_idx;
  logic [47:0]   frame_reg;
  logic [23:0]   buf_l_reg, buf_r_reg;
  logic          buf_full_reg, first_reg;
  logic [RW-1:0] req_cnt_reg;
  logic          req_reg, underrun_reg;

  always_ff @(posedge rsync_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    div_wrap   = (div_reg == DIV_LAST);
    frame_end  = div_wrap && (bit_reg == 6'd47);
    div_adv    = div_wrap ? '0 : div_reg + 1'b1;
    bit_adv    = !div_wrap ? bit_reg : (bit_reg == 6'd47) ? 6'd0 : bit_reg + 6'd1;
    state_next = state_reg;
    div_next   = div_adv;
    bit_next   = bit_adv;
    case (state_reg)
      IDLE: begin
        div_next = '0;
        bit_next = 6'd0;
        if (play_in) state_next = RUN;
      end
      RUN: begin
        if (!play_in) state_next = frame_end ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (play_in)        state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) begin
      div_next = '0;
      bit_next = 6'd0;
    end
    load_next = (state_next == RUN) && (div_next == '0) && (bit_next == 6'd0);

    // Outputs are computed from the next position so they line up with the counters.
    sck_next = (state_next != IDLE) && (div_next >= DIV_HALF);
    ws_next  = (state_next != IDLE) && (bit_next >= 6'd24);
    sdo_idx  = 6'd48 - bit_next;
    sdo_next = sdo_reg;
    if (state_next == IDLE)
      sdo_next = 1'b0;
    else if (div_next == '0)
      sdo_next = (bit_next == 6'd0) ? frame_reg[0] : frame_reg[sdo_idx];
  end

  always_ff @(posedge rsync_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg      <= '0;
      bit_reg      <= 6'd0;
      sck_reg      <= 1'b0;
      ws_reg       <= 1'b0;
      sdo_reg      <= 1'b0;
      frame_reg    <= '0;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
      buf_full_reg <= 1'b0;
      first_reg    <= 1'b1;
      req_cnt_reg  <= '0;
      req_reg      <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      sck_reg      <= sck_next;
      ws_reg       <= ws_next;
      sdo_reg      <= sdo_next;
      // The first frame after IDLE is always silent, whatever the buffer holds.
      underrun_reg <= load_next && (first_reg || !buf_full_reg);

      if (load_next)
        frame_reg <= (buf_full_reg && !first_reg) ? {buf_l_reg, buf_r_reg} : '0;
      else if (state_next == IDLE)
        frame_reg <= '0;

      if (load_next)               first_reg <= 1'b0;
      else if (state_next == IDLE) first_reg <= 1'b1;

      // A coincident tick lands after the load has taken the old contents.
      if (tick_in) begin
        buf_l_reg    <= audio0_in;
        buf_r_reg    <= audio1_in;
        buf_full_reg <= 1'b1;
      end else if (load_next && !first_reg) begin
        buf_full_reg <= 1'b0;
      end else if (state_next == IDLE && state_reg != IDLE) begin
        buf_l_reg    <= '0;
        buf_r_reg    <= '0;
        buf_full_reg <= 1'b0;
      end

      if (load_next) begin
        req_reg     <= 1'b1;
        req_cnt_reg <= RW'(REQ_LEN - 1);
      end else if (state_next == IDLE) begin
        req_reg     <= 1'b0;
        req_cnt_reg <= '0;
      end else if (req_cnt_reg != '0) begin
        req_cnt_reg <= req_cnt_reg - 1'b1;
      end else begin
        req_reg <= 1'b0;
      end
    end
  end

  assign req_out      = req_reg;
  assign sck_out      = sck_reg;
  assign ws_out       = ws_reg;
  assign sdo_out      = sdo_reg;
  assign underrun_out = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_unit.sv
// Directed bench for i2s_tx_unit: frames are captured bit by bit and compared
// against hand-assembled {prev right bit 0, left[23:0], right[23:1]} vectors.
module tb_i2s_tx_unit;

  logic        rsync_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        play_in   = 1'b0;
  logic        tick_in   = 1'b0;
  logic [23:0] audio0_in = '0;
  logic [23:0] audio1_in = '0;
  logic        req_out, sck_out, ws_out, sdo_out, underrun_out;

  int checks   = 0;
  int failures = 0;

  int          t_at [4];
  logic [23:0] t_l  [4];
  logic [23:0] t_r  [4];
  int          n_t          = 0;
  int          play_off_at  = -1;

  i2s_tx_unit #(.MCLK_DIV(4), .REQ_LEN(8)) dut (
    .rsync_clk    (rsync_clk),
    .rst_n        (rst_n),
    .play_in      (play_in),
    .tick_in      (tick_in),
    .audio0_in    (audio0_in),
    .audio1_in    (audio1_in),
    .req_out      (req_out),
    .sck_out      (sck_out),
    .ws_out       (ws_out),
    .sdo_out      (sdo_out),
    .underrun_out (underrun_out)
  );

  always #5 rsync_clk = ~rsync_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {sck_out, ws_out, sdo_out, req_out, underrun_out};
  endfunction

  task automatic add_tick(input int c, input logic [23:0] l, input logic [23:0] r);
    t_at[n_t] = c;
    t_l[n_t]  = l;
    t_r[n_t]  = r;
    n_t++;
  endtask

  // Called with the current observation at cycle 0 of a frame; returns at cycle 0 of the next.
  task automatic run_frame(input string tag, input logic [47:0] exp_cap, input bit exp_ur);
    logic [47:0] cap;
    int e_sck, e_ws, e_req, e_ur;
    cap = '0; e_sck = 0; e_ws = 0; e_req = 0; e_ur = 0;
    for (int c = 0; c < 192; c++) begin
      if (c % 4 == 1) cap[47 - (c / 4)] = sdo_out;
      if (sck_out !== ((c % 4) >= 2)) e_sck++;
      if (ws_out !== (c >= 96)) e_ws++;
      if (req_out !== (c < 8)) e_req++;
      if (underrun_out !== (exp_ur && c == 0)) e_ur++;
      tick_in = 1'b0;
      for (int k = 0; k < n_t; k++) begin
        if (t_at[k] == c) begin
          tick_in   = 1'b1;
          audio0_in = t_l[k];
          audio1_in = t_r[k];
        end
      end
      if (c == play_off_at) play_in = 1'b0;
      @(negedge rsync_clk);
    end
    tick_in = 1'b0;
    n_t = 0;
    play_off_at = -1;
    chk({tag, "_data"}, cap, exp_cap);
    chk({tag, "_sck"}, e_sck, 0);
    chk({tag, "_ws"}, e_ws, 0);
    chk({tag, "_req"}, e_req, 0);
    chk({tag, "_underrun"}, e_ur, 0);
    $display("frame %s captured=%012h", tag, cap);
  endtask

  initial begin
    int errs;
    // Reset held with ticks toggling
    for (int i = 0; i < 20; i++) begin
      @(negedge rsync_clk);
      tick_in   = ~tick_in;
      audio0_in = 24'($urandom);
      audio1_in = 24'($urandom);
    end
    chk("reset_outs", outs(), 5'b0);
    tick_in = 1'b0;
    rst_n   = 1'b1;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge rsync_clk);
      if (outs() !== 5'b0) errs++;
    end
    chk("idle_quiet", errs, 0);
    $display("idle 500 cycles, nonzero output cycles=%0d", errs);

    // Start with an empty buffer; load a pair after the request falls
    play_in = 1'b1;
    @(negedge rsync_clk);
    chk("first_underrun", underrun_out, 1'b1);
    add_tick(20, 24'hA5A5A5, 24'h800001);
    run_frame("A_empty", 48'h0, 1'b1);

    add_tick(30, 24'h111111, 24'h333333);
    add_tick(100, 24'h222222, 24'h444444);
    run_frame("B_a5", {1'b0, 24'hA5A5A5, 23'h400000}, 1'b0);

    add_tick(50, 24'h654321, 24'hABCDEF);
    add_tick(191, 24'h0F0F0F, 24'h123457);
    run_frame("C_newest", {1'b1, 24'h222222, 23'h222222}, 1'b0);

    run_frame("D_oldbuf", {1'b0, 24'h654321, 23'h55E6F7}, 1'b0);

    // Stop requested at period 10: frame must still complete
    play_off_at = 40;
    run_frame("E_stop", {1'b1, 24'h0F0F0F, 23'h091A2B}, 1'b0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (outs() !== 5'b0) errs++;
      @(negedge rsync_clk);
    end
    chk("stop_idle", errs, 0);

    // Reset at period 30 with a pending sample in the buffer
    play_in = 1'b1;
    @(negedge rsync_clk);
    for (int c = 0; c < 120; c++) begin
      tick_in = (c == 20);
      audio0_in = 24'h777777;
      audio1_in = 24'h888888;
      @(negedge rsync_clk);
    end
    tick_in = 1'b0;
    chk("pre_reset_ws", ws_out, 1'b1);
    rst_n   = 1'b0;
    play_in = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 5'b0);
    repeat (3) @(negedge rsync_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge rsync_clk);
    play_in = 1'b1;
    @(negedge rsync_clk);
    run_frame("R1_after_reset", 48'h0, 1'b1);
    run_frame("R2_buf_empty", 48'h0, 1'b1);
    play_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx_unit.md
Name: i2s_tx_unit

Overview:
- Serialiser stage in the mclk domain, directly downstream of the audio clock-domain-crossing stage.
- Accepts one stereo sample pair per tick_in into a single-entry holding buffer.
- Transmits each pair as a 48-bit I2S frame (24 bits per channel, MSB first, one-bit WS delay) on sck_out, ws_out and sdo_out.
- Once per frame, raises req_out to request the next sample pair across the domain boundary.

Parameters:
- MCLK_DIV, 4, rsync_clk cycles per sck period; even, >= 2.
- REQ_LEN, 8, rsync_clk cycles req_out is held high per frame; 1 <= REQ_LEN < 48*MCLK_DIV.

Ports:
- rsync_clk  in  1  block clock (mux-selected audio clock)
- rst_n  in  1  reset, asynchronous, active-low
- play_in  in  1  synchronised play enable
- tick_in  in  1  one-cycle strobe: audio0_in/audio1_in valid
- audio0_in  in  24  left sample, two's complement
- audio1_in  in  24  right sample, two's complement
- req_out  out  1  sample request; the falling edge is the request event
- sck_out  out  1  I2S bit clock
- ws_out  out  1  I2S word select (0 = left, 1 = right)
- sdo_out  out  1  I2S serial data
- underrun_out  out  1  one-cycle pulse: frame loaded with an empty buffer

Behaviour:
- Reset: all outputs 0; state IDLE; div_cnt = 0; bit_cnt = 0; holding buffer empty and 0; shift data 0.
- All outputs are registered; no combinational input-to-output paths.
- States:
  - IDLE: counters held at 0; outputs 0. On play_in = 1, go to RUN next cycle; the first cycle in RUN is period 0, div_cnt = 0.
  - RUN: div_cnt counts 0..MCLK_DIV-1 and wraps; bit_cnt (period index 0..47) increments at each div_cnt wrap and wraps 47 -> 0.
  - STOPPING: entered when play_in = 0 during RUN. The current frame completes; at the end of period 47, go to IDLE with counters at 0 and outputs 0. If play_in returns to 1 while in STOPPING, go back to RUN with no frame break.
- sck_out: 0 while div_cnt < MCLK_DIV/2, 1 otherwise. Data and ws change only at div_cnt = 0 (sck falling edge); the receiver samples on the rising edge.
- ws_out: 0 in periods 0..23; 1 in periods 24..47.
- sdo_out:
  - period 0: right bit 0 of the previous frame (0 in the first frame after IDLE)
  - periods 1..24: left bits 23..0
  - periods 25..47: right bits 23..1
- Frame load (div_cnt = 0, bit_cnt = 0, RUN):
  - Buffer full: copy the buffer into the shift data and mark the buffer empty.
  - Buffer empty: load 0/0 and pulse underrun_out for 1 cycle. The first frame after IDLE always underruns.
  - At the same cycle, req_out rises and stays high REQ_LEN cycles, then falls.
- tick_in:
  - Writes the buffer and sets it full, in any state.
  - If the buffer is already full, new data overwrites it (newest wins).
  - If tick_in coincides with a frame load, the load takes the old buffer contents and the tick's data then fills the buffer (buffer ends full).
- Return to IDLE clears the buffer to empty. req_out is never asserted in IDLE.
- rst_n low mid-frame: immediate asynchronous return to reset values, with no completion of the frame.

Test Plan:
- Reset with play_in = 0 and tick_in toggling -> all outputs 0, no sck activity for 500 cycles.
- play_in = 1 with buffer empty -> underrun_out pulses at RUN cycle 0; req_out high cycles 0..7; sdo_out = 0 for the whole frame; sck period 4 cycles; ws_out rises at cycle 96 and falls at cycle 192.
- tick_in with audio0 = 0xA5A5A5, audio1 = 0x800001 after the req_out fall -> next frame: ws = 0 periods carry A5A5A5 MSB-first from period 1; right bits 23..1 in periods 25..47 = 1 then 22 zeros; bit 0 = 1 appears in period 0 of the following frame; no underrun_out.
- Two tick_in strobes (0x111111 then 0x222222) in one frame -> the next frame transmits left = 0x222222.
- tick_in exactly on the frame-load cycle -> the current frame sends the old buffer; the following frame sends the tick's data.
- play_in = 0 at period 10 -> the frame finishes through period 47, then IDLE with outputs 0. Separately, rst_n pulse at period 30 -> outputs 0 on the next observed cycle and the buffer is empty.
